sram_frame_tx: RTL and testbench
================================

SRAM_FRAME_TX -- requirements
Module: sram_frame_tx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter WORDS, default 32, 32-bit words per frame (range 1..32).
REQ-003 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to transmit one frame.
REQ-006 SHALL have port ram_raddr  output  5  fabric SRAM read address (word index).
REQ-007 SHALL have port ram_rdata  input  32  fabric SRAM read data, valid one cycle after ram_raddr.
REQ-008 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  tx_data valid.
REQ-010 SHALL have port tx_ready  input  1  UART accepts byte.
REQ-011 SHALL have port tx_idle  input  1  UART shifter empty, line idle.
REQ-012 SHALL have port rs485_de  output  1  RS485 driver enable.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement FSM states IDLE, SYNC, LEN, RD_REQ, RD_WAIT, DATA, CSUM, DRAIN, FIN.
REQ-016 SHALL leave IDLE only on start=1; next state SYNC, busy=1 and rs485_de=1 from the following cycle.
REQ-017 SHALL ignore start whenever busy=1.
REQ-018 SHALL send frame bytes in order: SYNC_BYTE, LEN, WORDS*4 data bytes, CSUM.
REQ-019 SHALL compute LEN = (WORDS*4) mod 256.
REQ-020 SHALL read words at ram_raddr = 0..WORDS-1 in ascending order, one read per word.
REQ-021 SHALL drive ram_raddr in RD_REQ, capture ram_rdata into a 32-bit shift register in RD_WAIT, then enter DATA.
REQ-022 SHALL transmit each word as 4 bytes, MSB first ([31:24] first, [7:0] last).
REQ-023 SHALL, after the 4th byte of a word, go to RD_REQ if words remain, else CSUM.
REQ-024 SHALL compute CSUM as the 8-bit XOR of LEN and all data bytes; SYNC_BYTE is excluded.
REQ-025 SHALL treat a byte as transferred on a rising edge where tx_valid=1 and tx_ready=1.
REQ-026 SHALL hold tx_data stable and tx_valid=1 from first assertion until transfer; SHALL NOT drop tx_valid without transfer.
REQ-027 SHALL keep tx_valid=0 in IDLE, RD_REQ, RD_WAIT, DRAIN and FIN.
REQ-028 SHALL enter DRAIN after CSUM transfer and stay there until tx_idle=1.
REQ-029 SHALL, on tx_idle=1 in DRAIN, enter FIN: rs485_de=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-030 SHALL hold ram_raddr at last driven value outside RD_REQ.
REQ-031 SHALL clear the checksum accumulator and word counter on start acceptance.
REQ-032 SHALL NOT issue a read beyond address WORDS-1; word counter SHALL NOT wrap.

Reset
REQ-033 SHALL, on RESETn=0, immediately set state=IDLE, tx_valid=0, tx_data=0, rs485_de=0, busy=0, done=0, ram_raddr=0, counters and checksum=0.
REQ-034 SHALL abort any frame in progress on reset and not resume it after reset release.
REQ-035 SHALL accept a new start on the first clock after RESETn deasserts.

Verification
REQ-036 SHALL verify: WORDS=32, RAM all 0, tx_ready=1, tx_idle=1 -> 131 bytes A5,80,128x00,80; done pulses once; rs485_de high throughout.
REQ-037 SHALL verify: RAM[i]=32'h01020304 for all i -> each word emits 01,02,03,04; CSUM=80 (XOR of 32 identical words cancels).
REQ-038 SHALL verify: tx_ready=0 for 5 cycles mid-word -> tx_data unchanged, no byte dropped or duplicated, total 131 bytes.
REQ-039 SHALL verify: tx_idle held 0 for 20 cycles after CSUM -> rs485_de stays 1; de drop and done occur on the cycle after tx_idle=1.
REQ-040 SHALL verify: start pulsed again while busy -> ignored, exactly one frame sent.
REQ-041 SHALL verify: RESETn=0 during byte 40 -> all outputs 0 next edge; new start after release sends a complete fresh frame beginning A5.

Source files
------------

// File: rtl/sram_frame_tx.sv
// Frame transmitter: reads WORDS 32-bit words from fabric SRAM and streams
// SYNC, LEN, data bytes (MSB first) and an XOR checksum to a UART, framing RS485 DE.
module sram_frame_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         WORDS     = 32
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start,
    output logic [4:0]  ram_raddr,
    input  logic [31:0] ram_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_idle,
    output logic        rs485_de,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LEN_BYTE  = 8'((WORDS * 4) % 256);
    localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SYNC    = 4'd1,
        LEN     = 4'd2,
        RD_REQ  = 4'd3,
        RD_WAIT = 4'd4,
        DATA    = 4'd5,
        CSUM    = 4'd6,
        DRAIN   = 4'd7,
        FIN     = 4'd8
    } state_t;

    state_t      state_r, state_s;
    logic [4:0]  word_cnt_r, word_cnt_s;
    logic [1:0]  byte_cnt_r, byte_cnt_s;
    logic [31:0] shift_r, shift_s;
    logic [7:0]  csum_r, csum_s;
    logic [4:0]  raddr_r, raddr_s;
    logic        valid_r, valid_s;
    logic        de_r, de_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        xfer_s;

    // The outgoing byte always sits in shift_r[31:24], so SYNC, LEN and CSUM
    // are loaded into the same register the data words shift through.
    assign xfer_s = valid_r & tx_ready;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        word_cnt_s = word_cnt_r;
        byte_cnt_s = byte_cnt_r;
        shift_s    = shift_r;
        csum_s     = csum_r;
        raddr_s    = raddr_r;
        valid_s    = valid_r;
        de_s       = de_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = SYNC;
                    busy_s     = 1'b1;
                    de_s       = 1'b1;
                    valid_s    = 1'b1;
                    shift_s    = {SYNC_BYTE, 24'h000000};
                    csum_s     = 8'h00;
                    word_cnt_s = 5'd0;
                    byte_cnt_s = 2'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            SYNC: begin
                if (xfer_s) begin
                    state_s = LEN;
                    shift_s = {LEN_BYTE, 24'h000000};
                end else begin
                    state_s = SYNC;
                end
            end
            LEN: begin
                if (xfer_s) begin
                    csum_s  = csum_r ^ shift_r[31:24];
                    valid_s = 1'b0;
                    raddr_s = word_cnt_r;
                    state_s = RD_REQ;
                end else begin
                    state_s = LEN;
                end
            end
            RD_REQ: begin
                state_s = RD_WAIT;
            end
            RD_WAIT: begin
                shift_s    = ram_rdata;
                byte_cnt_s = 2'd0;
                valid_s    = 1'b1;
                state_s    = DATA;
            end
            DATA: begin
                if (xfer_s) begin
                    csum_s = csum_r ^ shift_r[31:24];
                    if (byte_cnt_r == 2'd3) begin
                        if (word_cnt_r == LAST_WORD) begin
                            shift_s = {csum_r ^ shift_r[31:24], 24'h000000};
                            state_s = CSUM;
                        end else begin
                            word_cnt_s = word_cnt_r + 5'd1;
                            raddr_s    = word_cnt_r + 5'd1;
                            valid_s    = 1'b0;
                            state_s    = RD_REQ;
                        end
                    end else begin
                        byte_cnt_s = byte_cnt_r + 2'd1;
                        shift_s    = {shift_r[23:0], 8'h00};
                    end
                end else begin
                    state_s = DATA;
                end
            end
            CSUM: begin
                if (xfer_s) begin
                    valid_s = 1'b0;
                    state_s = DRAIN;
                end else begin
                    state_s = CSUM;
                end
            end
            DRAIN: begin
                // Hold the RS485 driver on until the UART shifter has emptied.
                if (tx_idle) begin
                    de_s    = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = FIN;
                end else begin
                    state_s = DRAIN;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                de_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r    <= IDLE;
            word_cnt_r <= 5'd0;
            byte_cnt_r <= 2'd0;
            shift_r    <= 32'h00000000;
            csum_r     <= 8'h00;
            raddr_r    <= 5'd0;
            valid_r    <= 1'b0;
            de_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            word_cnt_r <= word_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            shift_r    <= shift_s;
            csum_r     <= csum_s;
            raddr_r    <= raddr_s;
            valid_r    <= valid_s;
            de_r       <= de_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign ram_raddr = raddr_r;
    assign tx_data   = shift_r[31:24];
    assign tx_valid  = valid_r;
    assign rs485_de  = de_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_sram_frame_tx.sv
// Bench for sram_frame_tx: table of frame scenarios checked against a byte-list
// model of the frame built from the RAM image, plus a mid-frame reset sequence.
module tb_sram_frame_tx;

    localparam int WORDS  = 32;
    localparam int NBYTES = WORDS * 4 + 3;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        start;
    logic [4:0]  ram_raddr;
    logic [31:0] ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_idle;
    logic        rs485_de;
    logic        busy;
    logic        done;

    always #5 CLK = ~CLK;

    sram_frame_tx #(.SYNC_BYTE(8'hA5), .WORDS(WORDS)) dut (
        .CLK(CLK), .RESETn(RESETn), .start(start),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_idle(tx_idle), .rs485_de(rs485_de), .busy(busy), .done(done)
    );

    logic [31:0] ram [WORDS];
    always @(posedge CLK) ram_rdata <= ram[ram_raddr];

    typedef struct {
        logic [1:0]  fill;       // 0 constant word, 1 word i = i+1, 2 random
        logic [31:0] word;
        int          ready_pct;
        int          stall_at;   // bytes captured before a 5-cycle tx_ready stall
        int          restart_at; // bytes captured before a stray start pulse
        int          idle_hold;  // cycles tx_idle stays low after the checksum
        bit          use_model;
        logic [7:0]  exp_csum;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  cap[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  model_csum;
    int          done_cnt = 0;
    int          ready_pct = 100;
    int          stall_at = 0;
    int          stall_left = 0;
    bit          stalled = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tx_ready driver: random acceptance with an optional fixed stall window.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else if (stall_at > 0 && !stalled && cap.size() >= stall_at) begin
                stalled    = 1'b1;
                stall_left = 4;
                tx_ready   = 1'b0;
            end else begin
                tx_ready = ($urandom_range(0, 99) < ready_pct);
            end
        end
    end

    // Monitor: records transferred bytes and checks handshake hold and DE framing.
    initial begin
        logic       pend;
        logic [7:0] pend_data;
        logic       prev_done;
        pend = 1'b0;
        pend_data = 8'h00;
        prev_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                pend = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (pend) begin
                    check("hold_valid", {31'd0, tx_valid}, 32'd1);
                    check("hold_data", {24'd0, tx_data}, {24'd0, pend_data});
                end
                if (busy) check("de_while_busy", {31'd0, rs485_de}, 32'd1);
                else check("valid_while_not_busy", {31'd0, tx_valid}, 32'd0);
                if (done) begin
                    done_cnt++;
                    check("done_width", {31'd0, prev_done}, 32'd0);
                end
                prev_done = done;
                if (tx_valid && tx_ready) cap.push_back(tx_data);
                pend = tx_valid && !tx_ready;
                pend_data = tx_data;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_de"}, {31'd0, rs485_de}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_raddr"}, {27'd0, ram_raddr}, 32'd0);
    endtask

    // Fill RAM, build the expected frame as a plain byte list, then pulse start.
    task automatic launch(input vec_t v);
        logic [7:0] b;
        for (int w = 0; w < WORDS; w++) begin
            case (v.fill)
                2'd0:    ram[w] = v.word;
                2'd1:    ram[w] = 32'(w + 1);
                default: ram[w] = $urandom();
            endcase
        end
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'((WORDS * 4) % 256));
        model_csum = exp_q[1];
        for (int w = 0; w < WORDS; w++) begin
            for (int k = 3; k >= 0; k--) begin
                b = ram[w][8*k +: 8];
                exp_q.push_back(b);
                model_csum = model_csum ^ b;
            end
        end
        exp_q.push_back(model_csum);
        cap.delete();
        done_cnt   = 0;
        ready_pct  = v.ready_pct;
        stall_at   = v.stall_at;
        stalled    = 1'b0;
        stall_left = 0;
        tx_idle    = (v.idle_hold == 0);
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic finish_frame(input vec_t v);
        int k;
        int bad;
        logic [7:0] last;
        @(negedge CLK);
        check("first_busy", {31'd0, busy}, 32'd1);
        check("first_de", {31'd0, rs485_de}, 32'd1);
        check("first_valid", {31'd0, tx_valid}, 32'd1);
        check("first_byte", {24'd0, tx_data}, 32'hA5);
        if (v.restart_at > 0) begin
            k = 0;
            while (cap.size() < v.restart_at && k < 5000) begin @(negedge CLK); k++; end
            @(posedge CLK); #1 start = 1'b1;
            @(posedge CLK); #1 start = 1'b0;
        end
        if (v.idle_hold > 0) begin
            k = 0;
            while (cap.size() < NBYTES && k < 5000) begin @(negedge CLK); k++; end
            check("csum_reached", {31'd0, k < 5000}, 32'd1);
            repeat (v.idle_hold) begin
                @(negedge CLK);
                check("drain_de", {31'd0, rs485_de}, 32'd1);
                check("drain_done", {31'd0, done}, 32'd0);
            end
            tx_idle = 1'b1;
            @(negedge CLK);
            check("fin_done", {31'd0, done}, 32'd1);
            check("fin_de", {31'd0, rs485_de}, 32'd0);
            check("fin_busy", {31'd0, busy}, 32'd0);
        end
        k = 0;
        while (done_cnt == 0 && k < 6000) begin @(negedge CLK); k++; end
        check("frame_timeout", {31'd0, k < 6000}, 32'd1);
        repeat (30) @(negedge CLK);
        check("byte_count", 32'(cap.size()), 32'(NBYTES));
        bad = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
        check("frame_first_bad_index", 32'(bad), 32'hFFFFFFFF);
        last = (cap.size() > 0) ? cap[cap.size() - 1] : 8'h00;
        check("csum_byte", {24'd0, last}, {24'd0, v.use_model ? model_csum : v.exp_csum});
        check("done_count", 32'(done_cnt), 32'd1);
        check("after_busy", {31'd0, busy}, 32'd0);
        check("after_de", {31'd0, rs485_de}, 32'd0);
        check("after_valid", {31'd0, tx_valid}, 32'd0);
        check("raddr_hold", {27'd0, ram_raddr}, 32'(WORDS - 1));
        tx_idle = 1'b1;
    endtask

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int k;
        vecs[0] = '{2'd0, 32'h00000000, 100, 0, 0, 0, 1'b0, 8'h80};
        vecs[1] = '{2'd0, 32'h01020304, 100, 0, 0, 0, 1'b0, 8'h80};
        vecs[2] = '{2'd1, 32'h00000000, 100, 0, 0, 0, 1'b0, 8'hA0};
        vecs[3] = '{2'd0, 32'hDEADBEEF, 30, 0, 0, 0, 1'b0, 8'h80};
        vecs[4] = '{2'd2, 32'h00000000, 100, 12, 0, 0, 1'b1, 8'h00};
        vecs[5] = '{2'd2, 32'h00000000, 60, 0, 0, 20, 1'b1, 8'h00};
        vecs[6] = '{2'd2, 32'h00000000, 100, 0, 50, 0, 1'b1, 8'h00};
        vecs[7] = '{2'd2, 32'h00000000, 50, 0, 0, 3, 1'b1, 8'h00};
        rv      = '{2'd2, 32'h00000000, 100, 0, 0, 0, 1'b1, 8'h00};

        RESETn  = 1'b0;
        start   = 1'b0;
        tx_idle = 1'b1;
        for (int w = 0; w < WORDS; w++) ram[w] = 32'h0;
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK);
        #2 RESETn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            launch(vecs[i]);
            finish_frame(vecs[i]);
        end

        // Reset in the middle of byte 40, then a fresh frame right after release.
        @(posedge CLK);
        #1;
        launch(rv);
        k = 0;
        while (cap.size() < 40 && k < 5000) begin @(negedge CLK); k++; end
        check("reach_byte40", {31'd0, k < 5000}, 32'd1);
        @(posedge CLK);
        #2 RESETn = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        repeat (2) @(posedge CLK);
        #2 RESETn = 1'b1;
        launch(rv);
        finish_frame(rv);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
